// File: rtl/refill_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : refill_arb_pkg
// Description : Shared types and constants for the L1 refill arbiter.
//               - arb_state_t : arbiter FSM states
//               - req_id_t    : requester identity (I-cache / D-cache)
//               - BLOCK_W     : refill block width in bits
//               - OFFSET_W    : byte-offset bits inside one block
// Revision    : 1.0 - initial release
// ============================================================================
package refill_arb_pkg;

    localparam int BLOCK_W  = 128;
    localparam int OFFSET_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

endpackage : refill_arb_pkg
`default_nettype wire

// File: rtl/refill_arbiter_arb_pick2.sv
`default_nettype none
// ============================================================================
// Module      : arb_pick2
// Description : Combinational two-way picker for the refill arbiter.
//               A lone request always wins. On a tie, fixed mode picks D;
//               round-robin mode picks the requester not granted last.
// Ports       : i_req_i  - I-cache request
//               i_req_d  - D-cache request
//               i_last   - requester granted most recently
//               i_rr_en  - 1 = round-robin tie-break, 0 = D over I
//               o_any    - at least one request present
//               o_winner - selected requester (valid when o_any)
// Revision    : 1.0 - initial release
// ============================================================================
module arb_pick2
    import refill_arb_pkg::*;
(
    input  logic    i_req_i,
    input  logic    i_req_d,
    input  req_id_t i_last,
    input  logic    i_rr_en,
    output logic    o_any,
    output req_id_t o_winner
);

    always_comb begin
        o_any    = i_req_i | i_req_d;
        o_winner = REQ_I;
        if (i_req_i && i_req_d) begin
            // Tie: in round-robin mode hand the grant to whoever waited last time
            o_winner = (i_rr_en && (i_last == REQ_D)) ? REQ_I : REQ_D;
        end else if (i_req_d) begin
            o_winner = REQ_D;
        end
    end

endmodule : arb_pick2
`default_nettype wire

// File: rtl/refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : refill_arbiter
// Description : Shares the single main-memory block port between the I-cache
//               and D-cache miss requesters. One refill outstanding at a time:
//               IDLE -> ISSUE -> RESP -> IDLE.
// Build macro : REFILL_ARB_RR_EN - round-robin tie-break (pointer resets to I,
//               so the first tie goes to D). Undefined: fixed D-over-I.
// Ports       : CLK, RST            - clock, synchronous active-high reset
//               IREQ/IADDR/IDONE    - I-cache miss request, address, done pulse
//               DREQ/DADDR/DDONE    - D-cache miss request, address, done pulse
//               RBLOCK              - returned block, valid with IDONE/DDONE
//               MEM_REQ/MEM_ADDR    - memory read request, block-aligned addr
//               MEM_READY/MEM_BLOCK - memory delivery pulse and data
//               ERR                 - sticky memory-timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module refill_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int BLOCK_W = 128,
    parameter int TIMEOUT = 64
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IREQ,
    input  logic [ADDR_W-1:0]  IADDR,
    output logic               IDONE,
    input  logic               DREQ,
    input  logic [ADDR_W-1:0]  DADDR,
    output logic               DDONE,
    output logic [BLOCK_W-1:0] RBLOCK,
    output logic               MEM_REQ,
    output logic [ADDR_W-1:0]  MEM_ADDR,
    input  logic               MEM_READY,
    input  logic [BLOCK_W-1:0] MEM_BLOCK,
    output logic               ERR
);

    import refill_arb_pkg::*;

    // One spare bit is kept when TIMEOUT is zero so the counter stays legal
    localparam int                CNT_W        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  C_TIMEOUT    = CNT_W'(TIMEOUT);
    localparam logic [ADDR_W-1:0] C_ALIGN_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    arb_state_t         r_state_q, w_state_d;
    req_id_t            r_win_q,   w_win_d;
    logic [ADDR_W-1:0]  r_addr_q,  w_addr_d;
    logic [BLOCK_W-1:0] r_block_q, w_block_d;
    logic [CNT_W-1:0]   r_cnt_q,   w_cnt_d;
    logic               r_err_q,   w_err_d;

    req_id_t            w_pick;
    req_id_t            w_last;
    logic               w_rr_en;
    logic               w_any;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_timeout;

    // ------------------------------------------------------------------
    // Tie-break pointer
    // ------------------------------------------------------------------
`ifdef REFILL_ARB_RR_EN
    req_id_t r_last_q, w_last_d;

    always_comb begin
        w_last_d = r_last_q;
        if ((r_state_q == ARB_IDLE) && w_any) begin
            w_last_d = w_pick;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_last_q <= REQ_I;
        end else begin
            r_last_q <= w_last_d;
        end
    end

    assign w_last  = r_last_q;
    assign w_rr_en = 1'b1;
`else
    assign w_last  = REQ_I;
    assign w_rr_en = 1'b0;
`endif

    arb_pick2 u_pick (
        .i_req_i  (IREQ),
        .i_req_d  (DREQ),
        .i_last   (w_last),
        .i_rr_en  (w_rr_en),
        .o_any    (w_any),
        .o_winner (w_pick)
    );

    assign w_sel_addr = (w_pick == REQ_D) ? DADDR : IADDR;
    assign w_cnt_inc  = r_cnt_q + CNT_W'(1);

    // ------------------------------------------------------------------
    // Timeout detect: fires in the ISSUE cycle whose count reaches TIMEOUT.
    // A MEM_READY arriving in that same cycle still wins.
    // ------------------------------------------------------------------
    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign w_timeout = (r_state_q == ARB_ISSUE) && !MEM_READY && (w_cnt_inc == C_TIMEOUT);
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state_q <= ARB_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ARB_IDLE:  if (w_any) w_state_d = ARB_ISSUE;
            ARB_ISSUE: if (MEM_READY || w_timeout) w_state_d = ARB_RESP;
            ARB_RESP:  w_state_d = ARB_IDLE;
            default:   w_state_d = ARB_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        MEM_REQ = (r_state_q == ARB_ISSUE);
        IDONE   = (r_state_q == ARB_RESP) && (r_win_q == REQ_I);
        DDONE   = (r_state_q == ARB_RESP) && (r_win_q == REQ_D);
    end

    assign MEM_ADDR = r_addr_q;
    assign RBLOCK   = r_block_q;
    assign ERR      = r_err_q;

    // ------------------------------------------------------------------
    // Datapath: grant capture, timeout counter, block capture, error flag
    // ------------------------------------------------------------------
    always_comb begin
        w_win_d   = r_win_q;
        w_addr_d  = r_addr_q;
        w_block_d = r_block_q;
        w_cnt_d   = r_cnt_q;
        w_err_d   = r_err_q;
        case (r_state_q)
            ARB_IDLE: begin
                if (w_any) begin
                    w_win_d  = w_pick;
                    w_addr_d = w_sel_addr & C_ALIGN_MASK;
                    w_cnt_d  = '0;
                end
            end
            ARB_ISSUE: begin
                w_cnt_d = w_cnt_inc;
                if (MEM_READY) begin
                    w_block_d = MEM_BLOCK;
                end else if (w_timeout) begin
                    // Release the requester with an all-zero block
                    w_block_d = '0;
                    w_err_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_win_q   <= REQ_I;
            r_addr_q  <= '0;
            r_block_q <= '0;
            r_cnt_q   <= '0;
            r_err_q   <= 1'b0;
        end else begin
            r_win_q   <= w_win_d;
            r_addr_q  <= w_addr_d;
            r_block_q <= w_block_d;
            r_cnt_q   <= w_cnt_d;
            r_err_q   <= w_err_d;
        end
    end

endmodule : refill_arbiter
`default_nettype wire

// File: tb/tb_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_refill_arbiter
// Description : Self-checking bench for refill_arbiter (TIMEOUT = 8).
//               Expected grants, addresses and blocks come from a
//               transaction-level model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_refill_arbiter;

    localparam int ADDR_W  = 32;
    localparam int BLOCK_W = 128;
    localparam int TIMEOUT = 8;
`ifdef REFILL_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic               CLK = 1'b0;
    logic               RST;
    logic               IREQ, DREQ, MEM_READY;
    logic [ADDR_W-1:0]  IADDR, DADDR;
    logic [BLOCK_W-1:0] MEM_BLOCK;
    logic               IDONE, DDONE, MEM_REQ, ERR;
    logic [ADDR_W-1:0]  MEM_ADDR;
    logic [BLOCK_W-1:0] RBLOCK;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: was the most recent grant D, and the last block returned
    bit                 m_last_d;
    logic [BLOCK_W-1:0] m_rblock;

    refill_arbiter #(
        .ADDR_W  (ADDR_W),
        .BLOCK_W (BLOCK_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IREQ      (IREQ),
        .IADDR     (IADDR),
        .IDONE     (IDONE),
        .DREQ      (DREQ),
        .DADDR     (DADDR),
        .DDONE     (DDONE),
        .RBLOCK    (RBLOCK),
        .MEM_REQ   (MEM_REQ),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_READY (MEM_READY),
        .MEM_BLOCK (MEM_BLOCK),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic bit pick_d(bit ireq, bit dreq);
        if (ireq && dreq) return RR_MODE ? !m_last_d : 1'b1;
        return dreq;
    endfunction

    function automatic logic [ADDR_W-1:0] align(logic [ADDR_W-1:0] a);
        return (a / 16) * 16;
    endfunction

    function automatic logic [BLOCK_W-1:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        RST = 1'b1; IREQ = 0; DREQ = 0; MEM_READY = 0;
        IADDR = '0; DADDR = '0; MEM_BLOCK = '0;
        tick(); tick();
        n_checks++; if (IDONE !== 1'b0)    begin n_fail++; $display("FAIL reset_idone got %b exp 0", IDONE); end
        n_checks++; if (DDONE !== 1'b0)    begin n_fail++; $display("FAIL reset_ddone got %b exp 0", DDONE); end
        n_checks++; if (MEM_REQ !== 1'b0)  begin n_fail++; $display("FAIL reset_mem_req got %b exp 0", MEM_REQ); end
        n_checks++; if (ERR !== 1'b0)      begin n_fail++; $display("FAIL reset_err got %b exp 0", ERR); end
        n_checks++; if (MEM_ADDR !== '0)   begin n_fail++; $display("FAIL reset_mem_addr got %h exp 0", MEM_ADDR); end
        n_checks++; if (RBLOCK !== '0)     begin n_fail++; $display("FAIL reset_rblock got %h exp 0", RBLOCK); end
        RST = 1'b0;
        m_last_d = 1'b0;
        m_rblock = '0;
    endtask

    task automatic test_single_i();
        logic [BLOCK_W-1:0] blk;
        IREQ = 1'b1; IADDR = 32'h0000_1234;
        tick();
        n_checks++; if (MEM_REQ !== 1'b1)           begin n_fail++; $display("FAIL single_mem_req got %b exp 1", MEM_REQ); end
        n_checks++; if (MEM_ADDR !== 32'h0000_1230) begin n_fail++; $display("FAIL single_mem_addr got %h exp 00001230", MEM_ADDR); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (MEM_REQ !== 1'b1 || IDONE !== 1'b0) begin n_fail++; $display("FAIL single_wait%0d mem_req=%b idone=%b exp 1/0", i, MEM_REQ, IDONE); end
        end
        blk = rand_block();
        MEM_READY = 1'b1; MEM_BLOCK = blk;
        tick();
        MEM_READY = 1'b0;
        n_checks++; if (IDONE !== 1'b1)   begin n_fail++; $display("FAIL single_idone got %b exp 1", IDONE); end
        n_checks++; if (DDONE !== 1'b0)   begin n_fail++; $display("FAIL single_ddone got %b exp 0", DDONE); end
        n_checks++; if (RBLOCK !== blk)   begin n_fail++; $display("FAIL single_rblock got %h exp %h", RBLOCK, blk); end
        m_last_d = 1'b0; m_rblock = blk;
        tick();
        n_checks++; if (IDONE !== 1'b0 || MEM_REQ !== 1'b0) begin n_fail++; $display("FAIL single_after idone=%b mem_req=%b exp 0/0", IDONE, MEM_REQ); end
        IREQ = 1'b0;
    endtask

    task automatic test_tie();
        logic [BLOCK_W-1:0] blk;
        bit                 exp_d;
        int                 dones;
        dones = 0;
        IADDR = 32'h100; DADDR = 32'h200; IREQ = 1'b1; DREQ = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_d = pick_d(IREQ, DREQ);
            tick();
            n_checks++; if (MEM_ADDR !== (exp_d ? 32'h200 : 32'h100)) begin n_fail++; $display("FAIL tie%0d_mem_addr got %h exp %h", k, MEM_ADDR, exp_d ? 32'h200 : 32'h100); end
            repeat ($urandom_range(0, 3)) begin
                tick();
                n_checks++; if (IDONE || DDONE) begin n_fail++; $display("FAIL tie%0d_early_done idone=%b ddone=%b exp 0/0", k, IDONE, DDONE); end
            end
            blk = rand_block();
            MEM_READY = 1'b1; MEM_BLOCK = blk;
            tick();
            MEM_READY = 1'b0;
            n_checks++; if ({DDONE, IDONE} !== (exp_d ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL tie%0d_done got d=%b i=%b exp d=%b", k, DDONE, IDONE, exp_d); end
            n_checks++; if (RBLOCK !== blk) begin n_fail++; $display("FAIL tie%0d_rblock got %h exp %h", k, RBLOCK, blk); end
            dones += int'(IDONE) + int'(DDONE);
            m_last_d = exp_d; m_rblock = blk;
            tick();
            n_checks++; if (IDONE || DDONE) begin n_fail++; $display("FAIL tie%0d_after idone=%b ddone=%b exp 0/0", k, IDONE, DDONE); end
            if (exp_d) DREQ = 1'b0; else IREQ = 1'b0;
        end
        n_checks++; if (dones !== 2) begin n_fail++; $display("FAIL tie_done_count got %0d exp 2", dones); end
    endtask

    task automatic test_tie_repeat();
        logic [BLOCK_W-1:0] blk;
        bit                 exp_d;
        IADDR = 32'hA000_0047; DADDR = 32'hB000_00F9; IREQ = 1'b1; DREQ = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_d = pick_d(IREQ, DREQ);
            tick();
            n_checks++; if (MEM_ADDR !== align(exp_d ? DADDR : IADDR)) begin n_fail++; $display("FAIL rep%0d_mem_addr got %h exp %h", k, MEM_ADDR, align(exp_d ? DADDR : IADDR)); end
            repeat ($urandom_range(0, 3)) tick();
            blk = rand_block();
            MEM_READY = 1'b1; MEM_BLOCK = blk;
            tick();
            MEM_READY = 1'b0;
            n_checks++; if ({DDONE, IDONE} !== (exp_d ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rep%0d_winner got d=%b i=%b exp d=%b", k, DDONE, IDONE, exp_d); end
            m_last_d = exp_d; m_rblock = blk;
            tick();
            if (!RR_MODE) begin
                IREQ = 1'b0; DREQ = 1'b0;
                tick();
                IREQ = 1'b1; DREQ = 1'b1;
            end
        end
        IREQ = 1'b0; DREQ = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        IREQ = 1'b1; IADDR = $urandom;
        tick();
        n_checks++; if (MEM_REQ !== 1'b1) begin n_fail++; $display("FAIL to_mem_req got %b exp 1", MEM_REQ); end
        for (int i = 1; i < TIMEOUT; i++) begin
            tick();
            n_checks++; if (MEM_REQ !== 1'b1 || ERR !== 1'b0 || IDONE !== 1'b0) begin n_fail++; $display("FAIL to_wait%0d mem_req=%b err=%b idone=%b exp 1/0/0", i, MEM_REQ, ERR, IDONE); end
        end
        tick();
        n_checks++; if (IDONE !== 1'b1)  begin n_fail++; $display("FAIL to_idone got %b exp 1", IDONE); end
        n_checks++; if (RBLOCK !== '0)   begin n_fail++; $display("FAIL to_rblock got %h exp 0", RBLOCK); end
        n_checks++; if (ERR !== 1'b1)    begin n_fail++; $display("FAIL to_err got %b exp 1", ERR); end
        n_checks++; if (MEM_REQ !== 1'b0) begin n_fail++; $display("FAIL to_mem_req_off got %b exp 0", MEM_REQ); end
        tick();
        IREQ = 1'b0;
        repeat (3) tick();
        n_checks++; if (ERR !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky got %b exp 1", ERR); end
        RST = 1'b1; tick(); RST = 1'b0;
        n_checks++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL to_err_cleared got %b exp 0", ERR); end
        m_last_d = 1'b0; m_rblock = '0;
    endtask

    task automatic test_reset_mid();
        DREQ = 1'b1; DADDR = $urandom;
        tick(); tick();
        RST = 1'b1;
        tick();
        n_checks++; if (MEM_REQ !== 1'b0) begin n_fail++; $display("FAIL rstmid_mem_req got %b exp 0", MEM_REQ); end
        n_checks++; if (MEM_ADDR !== '0)  begin n_fail++; $display("FAIL rstmid_mem_addr got %h exp 0", MEM_ADDR); end
        RST = 1'b0; DREQ = 1'b0;
        MEM_READY = 1'b1; MEM_BLOCK = rand_block();
        tick();
        MEM_READY = 1'b0;
        n_checks++; if (DDONE || IDONE || MEM_REQ) begin n_fail++; $display("FAIL rstmid_late1 ddone=%b idone=%b mem_req=%b exp 0/0/0", DDONE, IDONE, MEM_REQ); end
        tick();
        n_checks++; if (DDONE || IDONE) begin n_fail++; $display("FAIL rstmid_late2 ddone=%b idone=%b exp 0/0", DDONE, IDONE); end
        n_checks++; if (RBLOCK !== '0)  begin n_fail++; $display("FAIL rstmid_rblock got %h exp 0", RBLOCK); end
        m_last_d = 1'b0; m_rblock = '0;
    endtask

    task automatic test_ready_idle();
        for (int i = 0; i < 4; i++) begin
            MEM_READY = 1'b1; MEM_BLOCK = rand_block();
            tick();
            n_checks++; if (IDONE || DDONE || MEM_REQ) begin n_fail++; $display("FAIL rdyidle%0d idone=%b ddone=%b mem_req=%b exp 0/0/0", i, IDONE, DDONE, MEM_REQ); end
            n_checks++; if (RBLOCK !== m_rblock) begin n_fail++; $display("FAIL rdyidle%0d_rblock got %h exp %h", i, RBLOCK, m_rblock); end
        end
        MEM_READY = 1'b0;
    endtask

    task automatic test_random();
        logic [BLOCK_W-1:0] blk;
        bit                 exp_d;
        for (int n = 0; n < 40; n++) begin
            if (!IREQ && ($urandom_range(0, 2) != 0)) begin IREQ = 1'b1; IADDR = $urandom; end
            if (!DREQ && ($urandom_range(0, 2) != 0)) begin DREQ = 1'b1; DADDR = $urandom; end
            if (!IREQ && !DREQ) begin
                MEM_READY = $urandom_range(0, 1); MEM_BLOCK = rand_block();
                tick();
                MEM_READY = 1'b0;
                n_checks++; if (IDONE || DDONE || MEM_REQ || RBLOCK !== m_rblock) begin n_fail++; $display("FAIL rnd%0d_idle idone=%b ddone=%b mem_req=%b rblock=%h exp 0/0/0/%h", n, IDONE, DDONE, MEM_REQ, RBLOCK, m_rblock); end
            end else begin
                exp_d = pick_d(IREQ, DREQ);
                tick();
                n_checks++; if (MEM_REQ !== 1'b1 || MEM_ADDR !== align(exp_d ? DADDR : IADDR)) begin n_fail++; $display("FAIL rnd%0d_issue mem_req=%b mem_addr=%h exp 1/%h", n, MEM_REQ, MEM_ADDR, align(exp_d ? DADDR : IADDR)); end
                repeat ($urandom_range(0, 4)) begin
                    tick();
                    n_checks++; if (MEM_REQ !== 1'b1 || IDONE || DDONE) begin n_fail++; $display("FAIL rnd%0d_wait mem_req=%b idone=%b ddone=%b exp 1/0/0", n, MEM_REQ, IDONE, DDONE); end
                end
                blk = rand_block();
                MEM_READY = 1'b1; MEM_BLOCK = blk;
                tick();
                MEM_READY = 1'b0;
                n_checks++; if ({DDONE, IDONE} !== (exp_d ? 2'b10 : 2'b01) || RBLOCK !== blk) begin n_fail++; $display("FAIL rnd%0d_done d=%b i=%b rblock=%h exp d=%b rblock=%h", n, DDONE, IDONE, RBLOCK, exp_d, blk); end
                m_last_d = exp_d; m_rblock = blk;
                tick();
                n_checks++; if (IDONE || DDONE || MEM_REQ) begin n_fail++; $display("FAIL rnd%0d_after idone=%b ddone=%b mem_req=%b exp 0/0/0", n, IDONE, DDONE, MEM_REQ); end
                if (exp_d) DREQ = 1'b0; else IREQ = 1'b0;
            end
        end
        IREQ = 1'b0; DREQ = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_i();
        test_tie();
        test_tie_repeat();
        test_timeout();
        test_reset_mid();
        test_ready_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_refill_arbiter
`default_nettype wire
